// File: rtl/cdb_eu_out_fifo.sv
// Per-execution-unit result buffer feeding the CDB arbiter.
// An EU retires results into a circular buffer; the head entry is presented to the
// arbiter via a valid/ready channel. Both handshake outputs come only from registered
// state, so cdb_ready_i (combinational from cdb_valid_o in the arbiter) never loops back.
// Ports:
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   flush_i                 synchronous flush, overrides push and pop
//   eu_valid_i/eu_ready_o   EU-side handshake; eu_* payload written on push
//   cdb_valid_o/cdb_ready_i arbiter-side handshake; cdb_* payload is the head entry
//   count_o                 number of occupied entries (0..DEPTH)
module cdb_eu_out_fifo #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned XLEN      = 64,
    parameter int unsigned ROB_IDX_W = 6,
    parameter int unsigned EXCEPT_W  = 6
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         flush_i,
    input  logic                         eu_valid_i,
    output logic                         eu_ready_o,
    input  logic [ROB_IDX_W-1:0]         eu_rob_idx_i,
    input  logic [XLEN-1:0]              eu_res_i,
    input  logic                         eu_except_raised_i,
    input  logic [EXCEPT_W-1:0]          eu_except_code_i,
    output logic                         cdb_valid_o,
    input  logic                         cdb_ready_i,
    output logic [ROB_IDX_W-1:0]         cdb_rob_idx_o,
    output logic [XLEN-1:0]              cdb_res_o,
    output logic                         cdb_except_raised_o,
    output logic [EXCEPT_W-1:0]          cdb_except_code_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [XLEN-1:0]      res;
        logic                 except_raised;
        logic [EXCEPT_W-1:0]  except_code;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [DEPTH-1:0]   entry_valid_q;
    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   tail_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_n;
    logic               not_empty_q;
    logic               eu_ready_q;
    logic               push_c;
    logic               pop_c;
    entry_t             wr_entry_c;
    entry_t             head_entry_c;

    // Handshakes qualified only by registered state.
    assign push_c = eu_valid_i & eu_ready_q;
    assign pop_c  = cdb_valid_o & cdb_ready_i;

    assign wr_entry_c = '{rob_idx:       eu_rob_idx_i,
                          res:           eu_res_i,
                          except_raised: eu_except_raised_i,
                          except_code:   eu_except_code_i};

    // Next occupancy; flush wins over any concurrent push/pop.
    always_comb begin
        count_n = count_q;
        unique case ({push_c, pop_c})
            2'b10:   count_n = count_q + CNT_W'(1);
            2'b01:   count_n = count_q - CNT_W'(1);
            default: count_n = count_q;
        endcase
        if (flush_i) begin
            count_n = '0;
        end
    end

    // Pointers, occupancy and registered handshake flags.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            entry_valid_q <= '0;
            not_empty_q   <= 1'b0;
            eu_ready_q    <= 1'b1;
        end else begin
            count_q     <= count_n;
            not_empty_q <= (count_n != CNT_W'(0));
            eu_ready_q  <= (count_n != CNT_W'(DEPTH));
            if (flush_i) begin
                head_q        <= '0;
                tail_q        <= '0;
                entry_valid_q <= '0;
            end else begin
                if (pop_c) begin
                    head_q                <= head_q + PTR_W'(1);
                    entry_valid_q[head_q] <= 1'b0;
                end
                if (push_c) begin
                    tail_q                <= tail_q + PTR_W'(1);
                    entry_valid_q[tail_q] <= 1'b1;
                end
            end
        end
    end

    // Payload storage is intentionally not reset; it is only observed behind a valid bit.
    always_ff @(posedge clk_i) begin
        if (push_c && !flush_i) begin
            mem_q[tail_q] <= wr_entry_c;
        end
    end

    assign head_entry_c = mem_q[head_q];

    // Head entry valid bit and occupancy agree by construction; both are registered.
    assign cdb_valid_o         = not_empty_q & entry_valid_q[head_q];
    assign eu_ready_o          = eu_ready_q;
    assign cdb_rob_idx_o       = head_entry_c.rob_idx;
    assign cdb_res_o           = head_entry_c.res;
    assign cdb_except_raised_o = head_entry_c.except_raised;
    assign cdb_except_code_o   = head_entry_c.except_code;
    assign count_o             = count_q;

endmodule

// File: tb/tb_cdb_eu_out_fifo.sv
// Self-checking bench for cdb_eu_out_fifo: directed scenarios plus a random
// push/pop/flush run against a queue model. Inputs change on the falling edge.
module tb_cdb_eu_out_fifo;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned XLEN      = 64;
    localparam int unsigned ROB_IDX_W = 6;
    localparam int unsigned EXCEPT_W  = 6;
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [XLEN-1:0]      res;
        logic                 exc;
        logic [EXCEPT_W-1:0]  code;
    } ent_t;

    logic                 clk_i = 1'b0;
    logic                 rst_n_i = 1'b0;
    logic                 flush_i = 1'b0;
    logic                 eu_valid_i = 1'b0;
    logic                 eu_ready_o;
    logic [ROB_IDX_W-1:0] eu_rob_idx_i = '0;
    logic [XLEN-1:0]      eu_res_i = '0;
    logic                 eu_except_raised_i = 1'b0;
    logic [EXCEPT_W-1:0]  eu_except_code_i = '0;
    logic                 cdb_valid_o;
    logic                 cdb_ready_i = 1'b0;
    logic [ROB_IDX_W-1:0] cdb_rob_idx_o;
    logic [XLEN-1:0]      cdb_res_o;
    logic                 cdb_except_raised_o;
    logic [EXCEPT_W-1:0]  cdb_except_code_o;
    logic [CNT_W-1:0]     count_o;

    int n_checks = 0;
    int n_fail   = 0;

    cdb_eu_out_fifo #(.DEPTH(DEPTH), .XLEN(XLEN), .ROB_IDX_W(ROB_IDX_W), .EXCEPT_W(EXCEPT_W)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .eu_valid_i(eu_valid_i), .eu_ready_o(eu_ready_o),
        .eu_rob_idx_i(eu_rob_idx_i), .eu_res_i(eu_res_i),
        .eu_except_raised_i(eu_except_raised_i), .eu_except_code_i(eu_except_code_i),
        .cdb_valid_o(cdb_valid_o), .cdb_ready_i(cdb_ready_i),
        .cdb_rob_idx_o(cdb_rob_idx_o), .cdb_res_o(cdb_res_o),
        .cdb_except_raised_o(cdb_except_raised_o), .cdb_except_code_o(cdb_except_code_o),
        .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    // Protocol monitor: valid held and payload stable while stalled; no push when full,
    // no pop when empty. Previous-edge sample is discarded across reset.
    logic                 p_have = 1'b0;
    logic                 p_valid, p_ready, p_flush;
    logic [ROB_IDX_W-1:0] p_rob;
    logic [XLEN-1:0]      p_res;
    always @(posedge clk_i) begin
        if (!rst_n_i) begin
            p_have = 1'b0;
        end else begin
            if (p_have && p_valid && !p_ready && !p_flush) begin
                n_checks++;
                if (cdb_valid_o !== 1'b1 || cdb_rob_idx_o !== p_rob || cdb_res_o !== p_res) begin
                    n_fail++;
                    $display("FAIL hold_stable: valid=%0b rob=%0d res=%h, required valid=1 rob=%0d res=%h",
                             cdb_valid_o, cdb_rob_idx_o, cdb_res_o, p_rob, p_res);
                end
            end
            n_checks++;
            if ((eu_ready_o === 1'b1 && count_o == CNT_W'(DEPTH)) ||
                (cdb_valid_o === 1'b1 && count_o == '0)) begin
                n_fail++;
                $display("FAIL over_underflow: count=%0d eu_ready=%0b cdb_valid=%0b",
                         count_o, eu_ready_o, cdb_valid_o);
            end
            p_have  = 1'b1;
            p_valid = cdb_valid_o;
            p_ready = cdb_ready_i;
            p_flush = flush_i;
            p_rob   = cdb_rob_idx_o;
            p_res   = cdb_res_o;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic drive(input logic v, input logic [ROB_IDX_W-1:0] rob, input logic [XLEN-1:0] res,
                         input logic exc, input logic [EXCEPT_W-1:0] code, input logic rdy, input logic fl);
        eu_valid_i = v; eu_rob_idx_i = rob; eu_res_i = res;
        eu_except_raised_i = exc; eu_except_code_i = code;
        cdb_ready_i = rdy; flush_i = fl;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        idle();
        rst_n_i = 1'b0;
        tick();
        n_checks++;
        if (cdb_valid_o !== 1'b0 || eu_ready_o !== 1'b1 || count_o !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%0b ready=%0b count=%0d, required 0/1/0", cdb_valid_o, eu_ready_o, count_o);
        end
        rst_n_i = 1'b1;
        tick();
    endtask

    task automatic test_single_stall();
        drive(1'b1, 6'd5, 64'hDEAD, 1'b0, '0, 1'b0, 1'b0);
        tick();
        idle();
        n_checks++;
        if (cdb_valid_o !== 1'b1 || cdb_rob_idx_o !== 6'd5 || cdb_res_o !== 64'hDEAD ||
            cdb_except_raised_o !== 1'b0 || count_o !== 3'd1) begin
            n_fail++;
            $display("FAIL single_push: valid=%0b rob=%0d res=%h cnt=%0d, required 1/5/dead/1",
                     cdb_valid_o, cdb_rob_idx_o, cdb_res_o, count_o);
        end
        for (int i = 0; i < 10; i++) tick();
        n_checks++;
        if (cdb_valid_o !== 1'b1 || cdb_rob_idx_o !== 6'd5 || cdb_res_o !== 64'hDEAD) begin
            n_fail++;
            $display("FAIL single_stall: valid=%0b rob=%0d res=%h, required 1/5/dead", cdb_valid_o, cdb_rob_idx_o, cdb_res_o);
        end
        cdb_ready_i = 1'b1;
        tick();
        idle();
        n_checks++;
        if (cdb_valid_o !== 1'b0 || count_o !== 3'd0) begin
            n_fail++;
            $display("FAIL single_pop: valid=%0b cnt=%0d, required 0/0", cdb_valid_o, count_o);
        end
    endtask

    task automatic test_full();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 6'(i), 64'(i * 16), 1'b0, '0, 1'b0, 1'b0);
            tick();
        end
        n_checks++;
        if (count_o !== 3'd4 || eu_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_count: cnt=%0d ready=%0b, required 4/0", count_o, eu_ready_o);
        end
        // Fifth result held off while stalled.
        drive(1'b1, 6'd5, 64'h55, 1'b0, '0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (count_o !== 3'd4 || cdb_rob_idx_o !== 6'd1) begin
            n_fail++;
            $display("FAIL full_holdoff: cnt=%0d head=%0d, required 4/1", count_o, cdb_rob_idx_o);
        end
        // Pop while full with the fifth still offered: the push must not happen.
        cdb_ready_i = 1'b1;
        tick();
        eu_valid_i = 1'b0;
        n_checks++;
        if (count_o !== 3'd3 || eu_ready_o !== 1'b1 || cdb_rob_idx_o !== 6'd2) begin
            n_fail++;
            $display("FAIL full_pop: cnt=%0d ready=%0b head=%0d, required 3/1/2", count_o, eu_ready_o, cdb_rob_idx_o);
        end
        for (int i = 2; i <= 4; i++) begin
            n_checks++;
            if (cdb_valid_o !== 1'b1 || cdb_rob_idx_o !== 6'(i) || cdb_res_o !== 64'(i * 16)) begin
                n_fail++;
                $display("FAIL drain_order: valid=%0b rob=%0d res=%h, required 1/%0d/%h",
                         cdb_valid_o, cdb_rob_idx_o, cdb_res_o, i, 64'(i * 16));
            end
            tick();
        end
        idle();
        n_checks++;
        if (cdb_valid_o !== 1'b0 || count_o !== 3'd0) begin
            n_fail++;
            $display("FAIL drain_empty: valid=%0b cnt=%0d (fifth entry leaked?), required 0/0", cdb_valid_o, count_o);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 6'd0, 64'h1000, 1'b0, '0, 1'b1, 1'b0);
        tick();
        for (int i = 1; i < 20; i++) begin
            n_checks++;
            if (cdb_valid_o !== 1'b1 || cdb_rob_idx_o !== 6'(i - 1) || cdb_res_o !== 64'(32'h1000 + i - 1)) begin
                n_fail++;
                $display("FAIL stream_head: valid=%0b rob=%0d res=%h, required 1/%0d/%h",
                         cdb_valid_o, cdb_rob_idx_o, cdb_res_o, i - 1, 64'(32'h1000 + i - 1));
            end
            drive(1'b1, 6'(i), 64'(32'h1000 + i), 1'b0, '0, 1'b1, 1'b0);
            tick();
            n_checks++;
            if (count_o !== 3'd1) begin
                n_fail++;
                $display("FAIL stream_count: cnt=%0d, required 1", count_o);
            end
        end
        eu_valid_i = 1'b0;
        n_checks++;
        if (cdb_rob_idx_o !== 6'd19) begin
            n_fail++;
            $display("FAIL stream_last: rob=%0d, required 19", cdb_rob_idx_o);
        end
        tick();
        idle();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 6'(10 + i), 64'hF0 + 64'(i), 1'b0, '0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 6'd13, 64'hF3, 1'b0, '0, 1'b1, 1'b1);
        tick();
        idle();
        n_checks++;
        if (count_o !== 3'd0 || cdb_valid_o !== 1'b0 || eu_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_state: cnt=%0d valid=%0b ready=%0b, required 0/0/1", count_o, cdb_valid_o, eu_ready_o);
        end
        drive(1'b1, 6'd20, 64'hABC, 1'b0, '0, 1'b0, 1'b0);
        tick();
        idle();
        n_checks++;
        if (cdb_valid_o !== 1'b1 || cdb_rob_idx_o !== 6'd20 || count_o !== 3'd1) begin
            n_fail++;
            $display("FAIL flush_after: valid=%0b rob=%0d cnt=%0d, required 1/20/1", cdb_valid_o, cdb_rob_idx_o, count_o);
        end
        cdb_ready_i = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 6'd9, 64'h99, 1'b1, 6'h02, 1'b0, 1'b0);
        tick();
        idle();
        n_checks++;
        if (cdb_valid_o !== 1'b1 || cdb_rob_idx_o !== 6'd9 || cdb_except_raised_o !== 1'b1 ||
            cdb_except_code_o !== 6'h02) begin
            n_fail++;
            $display("FAIL exc_push: valid=%0b rob=%0d exc=%0b code=%h, required 1/9/1/02",
                     cdb_valid_o, cdb_rob_idx_o, cdb_except_raised_o, cdb_except_code_o);
        end
        #2 rst_n_i = 1'b0;
        #1;
        n_checks++;
        if (cdb_valid_o !== 1'b0 || count_o !== 3'd0 || eu_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: valid=%0b cnt=%0d ready=%0b, required 0/0/1", cdb_valid_o, count_o, eu_ready_o);
        end
        tick();
        rst_n_i = 1'b1;
        drive(1'b1, 6'd7, 64'h77, 1'b0, 6'h00, 1'b0, 1'b0);
        tick();
        idle();
        n_checks++;
        if (cdb_valid_o !== 1'b1 || cdb_rob_idx_o !== 6'd7 || cdb_res_o !== 64'h77 ||
            cdb_except_raised_o !== 1'b0 || count_o !== 3'd1) begin
            n_fail++;
            $display("FAIL post_reset_push: valid=%0b rob=%0d res=%h exc=%0b cnt=%0d, required 1/7/77/0/1",
                     cdb_valid_o, cdb_rob_idx_o, cdb_res_o, cdb_except_raised_o, count_o);
        end
        cdb_ready_i = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_random();
        ent_t q[$];
        ent_t e;
        int   errs = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            e.rob_idx = 6'($urandom);
            e.res     = {32'($urandom), 32'($urandom)};
            e.exc     = 1'($urandom);
            e.code    = 6'($urandom);
            drive(($urandom_range(0, 99) < 60), e.rob_idx, e.res, e.exc, e.code,
                  ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 2));
            n_checks++;
            if (count_o !== CNT_W'(q.size()) || eu_ready_o !== (q.size() != DEPTH) ||
                cdb_valid_o !== (q.size() != 0)) begin
                n_fail++;
                if (errs++ < 10)
                    $display("FAIL rand_state cyc %0d: cnt=%0d ready=%0b valid=%0b, required cnt=%0d",
                             cyc, count_o, eu_ready_o, cdb_valid_o, q.size());
            end
            if (q.size() != 0) begin
                n_checks++;
                if (cdb_rob_idx_o !== q[0].rob_idx || cdb_res_o !== q[0].res ||
                    cdb_except_raised_o !== q[0].exc || cdb_except_code_o !== q[0].code) begin
                    n_fail++;
                    if (errs++ < 10)
                        $display("FAIL rand_payload cyc %0d: rob=%0d res=%h, required rob=%0d res=%h",
                                 cyc, cdb_rob_idx_o, cdb_res_o, q[0].rob_idx, q[0].res);
                end
            end
            if (flush_i) begin
                q.delete();
            end else begin
                logic can_push;
                can_push = (q.size() != DEPTH);
                if (cdb_ready_i && q.size() != 0) void'(q.pop_front());
                if (eu_valid_i && can_push) q.push_back(e);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_single_stall();
        test_full();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
